conv_bin_bcd_seq: RTL and testbench

- Sequential binary-to-packed-BCD converter for the RTC controller write path.
- Takes a 7-bit binary value (seconds, minutes, hours, date, month or year, 0..99) from the PicoBlaze-side logic. Produces the 8-bit packed BCD byte written to the RTC registers.
- Uses an iterative shift-and-add-3 (double-dabble) datapath with a start/done handshake and fixed latency.
- Range-checks the input against a parameterised limit.

---
 rtl/conv_bin_bcd_seq.sv | 77 +++++++
 tb/tb_conv_bin_bcd_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/conv_bin_bcd_seq.sv
// Sequential 7-bit binary to packed-BCD converter (shift-and-add-3), start/done handshake.
// Out-of-range operands (above MAX_VAL) complete with the same latency and report 8'hFF plus error.
//
// state | meaning
// IDLE  | waiting for start; done pulse is visible here after a conversion
// CONV  | seven adjust-and-shift iterations
// DONE  | result selected; outputs registered on the edge back to IDLE
module conv_bin_bcd_seq #(
    parameter int MAX_VAL = 99
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [6:0] dato_bin,
    output logic [7:0] dato_bcd,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    localparam logic [6:0] LIMIT = 7'(MAX_VAL);

    state_t      state;
    logic [14:0] shift_reg;
    logic [14:0] shift_adj;
    logic [2:0]  cnt;
    logic        range_err;

    // Each nibble is adjusted independently before the shift; no carry between nibbles.
    always_comb begin
        shift_adj = shift_reg;
        if (shift_reg[14:11] >= 4'd5) shift_adj[14:11] = shift_reg[14:11] + 4'd3;
        if (shift_reg[10:7]  >= 4'd5) shift_adj[10:7]  = shift_reg[10:7]  + 4'd3;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            cnt       <= '0;
            range_err <= 1'b0;
            dato_bcd  <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        shift_reg <= {8'h00, dato_bin};
                        cnt       <= 3'd7;
                        range_err <= (dato_bin > LIMIT);
                        busy      <= 1'b1;
                        state     <= CONV;
                    end
                end
                CONV: begin
                    shift_reg <= {shift_adj[13:0], 1'b0};
                    cnt       <= cnt - 3'd1;
                    if (cnt == 3'd1) state <= DONE;
                end
                DONE: begin
                    dato_bcd <= range_err ? 8'hFF : shift_reg[14:7];
                    error    <= range_err;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_bin_bcd_seq.sv
// Scoreboard bench for conv_bin_bcd_seq: two instances (limits 99 and 59) share stimulus,
// expectations come from decimal arithmetic and are checked when each instance pulses done.
module tb_conv_bin_bcd_seq;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] dato_bin = 7'd0;
    logic [7:0] bcd_a, bcd_b;
    logic       busy_a, busy_b, done_a, done_b, err_a, err_b;

    conv_bin_bcd_seq #(.MAX_VAL(99)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .dato_bin(dato_bin),
        .dato_bcd(bcd_a), .busy(busy_a), .done(done_a), .error(err_a)
    );

    conv_bin_bcd_seq #(.MAX_VAL(59)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .dato_bin(dato_bin),
        .dato_bcd(bcd_b), .busy(busy_b), .done(done_b), .error(err_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int         k;
        logic [7:0] bcd;
        logic       err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    function automatic exp_t model(input int v, input int maxv, input int k);
        exp_t e;
        int   tens, units;
        e.k = k;
        if (v > maxv) begin
            e.bcd = 8'hFF;
            e.err = 1'b1;
        end else begin
            tens  = v / 10;
            units = v % 10;
            e.bcd = 8'(tens * 16 + units);
            e.err = 1'b0;
        end
        return e;
    endfunction

    task automatic push(input int v, input int k);
        q0.push_back(model(v, 99, k));
        q1.push_back(model(v, 59, k));
    endtask

    task automatic mon(input int id, input logic [7:0] bcd, input logic busy,
                       input logic done, input logic err);
        exp_t e;
        int   n;
        logic exp_busy;
        n = (id == 0) ? q0.size() : q1.size();
        if (n > 0) e = (id == 0) ? q0[0] : q1[0];
        exp_busy = (n > 0) && (cyc >= e.k) && (cyc <= e.k + 7);
        check($sformatf("busy[%0d]", id), 32'(busy), 32'(exp_busy));
        if (done === 1'b1) begin
            if (n == 0) begin
                check($sformatf("unexpected_done[%0d]", id), 32'd1, 32'd0);
            end else begin
                check($sformatf("latency[%0d]", id), 32'(cyc - e.k), 32'd8);
                check($sformatf("dato_bcd[%0d]", id), 32'(bcd), 32'(e.bcd));
                check($sformatf("error[%0d]", id), 32'(err), 32'(e.err));
                if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
        end else if (n > 0 && cyc > e.k + 8) begin
            check($sformatf("done_timeout[%0d]", id), 32'd0, 32'd1);
            if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, bcd_a, busy_a, done_a, err_a);
            mon(1, bcd_b, busy_b, done_b, err_b);
        end
    end

    task automatic issue(input int v, input int gap);
        @(negedge clk);
        start    = 1'b1;
        dato_bin = 7'(v);
        push(v, cyc + 1);
        @(negedge clk);
        start    = 1'b0;
        dato_bin = 7'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bcd_a"}, 32'(bcd_a), 32'h00);
        check({tag, "_busy_a"}, 32'(busy_a), 32'd0);
        check({tag, "_done_a"}, 32'(done_a), 32'd0);
        check({tag, "_err_a"}, 32'(err_a), 32'd0);
        check({tag, "_bcd_b"}, 32'(bcd_b), 32'h00);
        check({tag, "_done_b"}, 32'(done_b), 32'd0);
    endtask

    initial begin
        int directed[8] = '{0, 9, 10, 59, 99, 100, 127, 42};
        int k0;

        // Reset held two cycles with start asserted.
        reset_n  = 1'b0;
        start    = 1'b1;
        dato_bin = 7'd5;
        @(posedge clk);
        repeat (2) begin
            @(negedge clk);
            check_reset_outputs("reset");
        end
        reset_n = 1'b1;
        start   = 1'b0;
        mon_en  = 1'b1;
        repeat (2) @(negedge clk);

        foreach (directed[i]) issue(directed[i], 9);
        issue(60, 8);

        // Extra start pulses during a conversion must be ignored.
        @(negedge clk);
        start    = 1'b1;
        dato_bin = 7'd23;
        push(23, cyc + 1);
        @(negedge clk);
        start    = 1'b0;
        dato_bin = 7'd77;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);

        // Start held high: conversions every 9 cycles.
        @(negedge clk);
        start    = 1'b1;
        dato_bin = 7'd37;
        k0 = cyc + 1;
        for (int j = 0; j < 4; j++) push(37, k0 + 9 * j);
        repeat (28) @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);

        // Reset in the middle of a conversion of 88.
        @(negedge clk);
        start    = 1'b1;
        dato_bin = 7'd88;
        push(88, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        q0.delete();
        q1.delete();
        @(negedge clk);
        check_reset_outputs("abort");
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_done_bcd", 32'(bcd_a), 32'h00);
        issue(88, 9);

        // Exhaustive sweep then random operands with random gaps.
        for (int v = 0; v < 128; v++) issue(v, 8);
        for (int r = 0; r < 40; r++) issue(int'($urandom_range(0, 127)), int'($urandom_range(8, 12)));

        repeat (12) @(negedge clk);
        check("leftover_a", 32'(q0.size()), 32'd0);
        check("leftover_b", 32'(q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
